// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: bus widths, the
// memory-request count codes and the count-to-beats decode.
package dmem_resp_pkg;

  // Datapath widths seen by the execute stage.
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = WORD_W / BYTE_W;

  // Request size codes; 2'd3 is reserved and reported as an error.
  localparam int MEM_COUNT_W = 2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd2;

  // Beat counter width: holds beat counts 1..4 and indices 0..3.
  localparam int BEAT_W = 3;

  typedef struct packed {
    logic              legal;
    logic [BEAT_W-1:0] beats;
  } beat_dec_t;

  // Translate a count code into the number of byte beats it needs.
  function automatic beat_dec_t mem_count_decode(input logic [MEM_COUNT_W-1:0] code);
    beat_dec_t dec;
    dec.legal = 1'b1;
    dec.beats = 3'd1;
    case (code)
      MEM_COUNT_BYTE: dec.beats = 3'd1;
      MEM_COUNT_HALF: dec.beats = 3'd2;
      MEM_COUNT_WORD: dec.beats = 3'd4;
      default: begin
        dec.legal = 1'b0;
        dec.beats = 3'd0;
      end
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/dmem_resp_byte_ram.sv
// Single-port byte-wide RAM: synchronous write, registered read, no reset
// so that it maps onto block RAM and keeps its contents across resets.
module byte_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [7:0]            i_wdata,
  output logic [7:0]            o_rdata
);

  logic [7:0] r_mem [0:(2**DEPTH_LOG2)-1];
  logic [7:0] r_rdata;

  // Write the addressed byte and register the (old) contents for read-back.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one byte/half/word request, serialises it
// into byte beats on an internal RAM and returns a one-cycle completion
// with little-endian, zero-extended read data.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   i_mem_req_valid,
  output logic                   o_mem_req_ready,
  input  logic [ADDR_W-1:0]      i_mem_req_addr,
  input  logic [WORD_W-1:0]      i_mem_req_wr_data,
  input  logic                   i_mem_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
  output logic                   o_mem_rsp_valid,
  output logic [WORD_W-1:0]      o_mem_rsp_rd_data,
  output logic                   o_mem_rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [WORD_W-1:0]     r_wr_data;
  logic                  r_wr_en;
  logic [BEAT_W-1:0]     r_beats;
  logic [BEAT_W-1:0]     r_beat;
  logic [WORD_W-1:0]     r_asm;
  logic                  r_rsp_valid;
  logic [WORD_W-1:0]     r_rsp_data;
  logic                  r_rsp_err;

  beat_dec_t             w_dec;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic                  w_ram_we;
  logic [7:0]            w_ram_wdata;
  logic [7:0]            w_ram_rdata;
  logic                  w_cap_en;
  logic [BEAT_W-1:0]     w_cap_lane;
  logic [WORD_W-1:0]     w_asm_next;
  logic                  w_last_beat;
  logic                  w_unused_addr_hi;

  assign w_dec = mem_count_decode(i_mem_req_count);

  // Only the low address bits select a RAM byte; the rest is ignored.
  assign w_unused_addr_hi = &{1'b0, i_mem_req_addr[ADDR_W-1:DEPTH_LOG2]};

  // Beat k touches (base + k), wrapping naturally at the RAM size.
  assign w_ram_addr  = r_addr + DEPTH_LOG2'(r_beat);
  assign w_ram_we    = (r_state == S_ACCESS) && r_wr_en;
  assign w_ram_wdata = 8'(r_wr_data >> {r_beat, 3'b000});
  assign w_last_beat = (r_beat == (r_beats - 3'd1));

  // RAM output lags the address by one cycle, so beat k lands byte k-1;
  // the final byte is picked up in DRAIN.
  assign w_cap_en   = ((r_state == S_ACCESS) && !r_wr_en && (r_beat != 3'd0)) ||
                      (r_state == S_DRAIN);
  assign w_cap_lane = (r_state == S_DRAIN) ? (r_beats - 3'd1) : (r_beat - 3'd1);

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign w_asm_next[gi*8 +: 8] = (w_cap_en && (w_cap_lane == 3'(gi))) ?
                                     w_ram_rdata : r_asm[gi*8 +: 8];
    end
  endgenerate

  byte_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Request FSM with registered response outputs; DONE lasts one cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_beats     <= '0;
      r_beat      <= '0;
      r_asm       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_mem_req_valid) begin
            r_addr    <= i_mem_req_addr[DEPTH_LOG2-1:0];
            r_wr_data <= i_mem_req_wr_data;
            r_wr_en   <= i_mem_req_wr_en;
            r_beats   <= w_dec.beats;
            r_beat    <= '0;
            r_asm     <= '0;
            if (w_dec.legal) begin
              r_state <= S_ACCESS;
            end else begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          r_asm <= w_asm_next;
          if (w_last_beat) begin
            if (r_wr_en) begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_beat <= r_beat + 3'd1;
          end
        end
        S_DRAIN: begin
          r_asm       <= w_asm_next;
          r_state     <= S_DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_asm_next;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_req_ready   = (r_state == S_IDLE);
  assign o_mem_rsp_valid   = r_rsp_valid;
  assign o_mem_rsp_rd_data = r_rsp_data;
  assign o_mem_rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: stimulus pushes expected responses,
// a negedge monitor pops and compares data, err flag and latency.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int DL2 = 12;

  logic                   clk = 1'b0;
  logic                   clr_n = 1'b0;
  logic                   i_mem_req_valid = 1'b0;
  logic                   o_mem_req_ready;
  logic [ADDR_W-1:0]      i_mem_req_addr = '0;
  logic [WORD_W-1:0]      i_mem_req_wr_data = '0;
  logic                   i_mem_req_wr_en = 1'b0;
  logic [MEM_COUNT_W-1:0] i_mem_req_count = '0;
  logic                   o_mem_rsp_valid;
  logic [WORD_W-1:0]      o_mem_rsp_rd_data;
  logic                   o_mem_rsp_err;

  dmem_resp #(.DEPTH_LOG2(DL2)) dut (
    .clk               (clk),
    .clr_n             (clr_n),
    .i_mem_req_valid   (i_mem_req_valid),
    .o_mem_req_ready   (o_mem_req_ready),
    .i_mem_req_addr    (i_mem_req_addr),
    .i_mem_req_wr_data (i_mem_req_wr_data),
    .i_mem_req_wr_en   (i_mem_req_wr_en),
    .i_mem_req_count   (i_mem_req_count),
    .o_mem_rsp_valid   (o_mem_rsp_valid),
    .o_mem_rsp_rd_data (o_mem_rsp_rd_data),
    .o_mem_rsp_err     (o_mem_rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (clr_n && o_mem_rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data 0x%08h err %0b, expected no response",
                 o_mem_rsp_rd_data, o_mem_rsp_err);
      end else begin
        e = sb.pop_front();
        check({e.name, ".data"}, o_mem_rsp_rd_data, e.data);
        check({e.name, ".err"}, 32'(o_mem_rsp_err), 32'(e.err));
        check({e.name, ".latency"}, 32'(cyc - e.acc), 32'(e.lat));
        $display("txn %-12s data=0x%08h err=%0b latency=%0d", e.name,
                 o_mem_rsp_rd_data, o_mem_rsp_err, cyc - e.acc);
      end
    end
  end

  // Issue one request; returns the accept cycle (-1 if ready never came).
  task automatic issue(input string name, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] cnt,
                       input logic [31:0] exp_d, input bit exp_e, input int lat,
                       input bit track, output int acc);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!o_mem_req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s.ready: got 0, expected 1 within 200 cycles", name);
      acc = -1;
      return;
    end
    i_mem_req_valid   = 1'b1;
    i_mem_req_wr_en   = wr;
    i_mem_req_addr    = addr;
    i_mem_req_wr_data = data;
    i_mem_req_count   = cnt;
    acc = cyc;
    if (track) begin
      e.data = exp_d;
      e.err  = exp_e;
      e.acc  = acc;
      e.lat  = lat;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    i_mem_req_valid   = 1'b0;
    i_mem_req_addr    = $urandom;
    i_mem_req_wr_data = $urandom;
    i_mem_req_wr_en   = 1'($urandom);
    i_mem_req_count   = 2'($urandom);
  endtask

  int a0, a1, guard;

  initial begin
    // Reset and check idle state after release.
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    #1;
    check("rst.ready", 32'(o_mem_req_ready), 32'd1);
    check("rst.valid", 32'(o_mem_rsp_valid), 32'd0);
    check("rst.data",  o_mem_rsp_rd_data, 32'd0);
    check("rst.err",   32'(o_mem_rsp_err), 32'd0);

    // Word write then read, with response timing.
    issue("wr_w_10", 1, 32'h10, 32'hDEADBEEF, MEM_COUNT_WORD, 32'h0, 0, 5, 1, a0);
    issue("rd_w_10", 0, 32'h10, 32'h0, MEM_COUNT_WORD, 32'hDEADBEEF, 0, 6, 1, a0);
    issue("rd_b_11", 0, 32'h11, 32'h0, MEM_COUNT_BYTE, 32'h000000BE, 0, 3, 1, a0);
    issue("rd_h_12", 0, 32'h12, 32'h0, MEM_COUNT_HALF, 32'h0000DEAD, 0, 4, 1, a0);

    // Misaligned half write spanning into the next word.
    issue("wr_h_13", 1, 32'h13, 32'h00001234, MEM_COUNT_HALF, 32'h0, 0, 3, 1, a0);
    issue("rd_w_10b", 0, 32'h10, 32'h0, MEM_COUNT_WORD, 32'h34ADBEEF, 0, 6, 1, a0);
    issue("rd_b_14", 0, 32'h14, 32'h0, MEM_COUNT_BYTE, 32'h00000012, 0, 3, 1, a0);

    // Word write wrapping past the top of the RAM.
    issue("wr_w_ffe", 1, 32'hFFE, 32'hA1B2C3D4, MEM_COUNT_WORD, 32'h0, 0, 5, 1, a0);
    issue("rd_b_000", 0, 32'h000, 32'h0, MEM_COUNT_BYTE, 32'h000000B2, 0, 3, 1, a0);
    issue("rd_b_001", 0, 32'h001, 32'h0, MEM_COUNT_BYTE, 32'h000000A1, 0, 3, 1, a0);
    issue("rd_b_1000", 0, 32'h0000_1000, 32'h0, MEM_COUNT_BYTE, 32'h000000B2, 0, 3, 1, a0);
    issue("rd_h_fff", 0, 32'hFFF, 32'h0, MEM_COUNT_HALF, 32'h0000B2C3, 0, 4, 1, a0);

    // Illegal count code: error in cycle 1, no RAM change.
    issue("illegal", 1, 32'h10, 32'hFFFFFFFF, 2'd3, 32'h0, 1, 1, 1, a0);
    issue("rd_w_10c", 0, 32'h10, 32'h0, MEM_COUNT_WORD, 32'h34ADBEEF, 0, 6, 1, a0);

    // Back-to-back throughput.
    issue("tp_rd_w0", 0, 32'h10, 32'h0, MEM_COUNT_WORD, 32'h34ADBEEF, 0, 6, 1, a0);
    issue("tp_rd_w1", 0, 32'h10, 32'h0, MEM_COUNT_WORD, 32'h34ADBEEF, 0, 6, 1, a1);
    check("tp_rd_word", 32'(a1 - a0), 32'd7);
    issue("tp_wr_w0", 1, 32'h40, 32'h01020304, MEM_COUNT_WORD, 32'h0, 0, 5, 1, a0);
    issue("tp_wr_w1", 1, 32'h44, 32'h05060708, MEM_COUNT_WORD, 32'h0, 0, 5, 1, a1);
    check("tp_wr_word", 32'(a1 - a0), 32'd6);
    issue("tp_rd_b0", 0, 32'h43, 32'h0, MEM_COUNT_BYTE, 32'h00000001, 0, 3, 1, a0);
    issue("tp_rd_b1", 0, 32'h44, 32'h0, MEM_COUNT_BYTE, 32'h00000008, 0, 3, 1, a1);
    check("tp_rd_byte", 32'(a1 - a0), 32'd4);

    // Reset in cycle 2 of a word write: only beat 0 has been written.
    issue("pre_w_20", 1, 32'h20, 32'h11223344, MEM_COUNT_WORD, 32'h0, 0, 5, 1, a0);
    issue("abort_w_20", 1, 32'h20, 32'h55667788, MEM_COUNT_WORD, 32'h0, 0, 0, 0, a0);
    @(posedge clk);
    #1;
    clr_n = 1'b0;
    #1;
    check("abort.valid", 32'(o_mem_rsp_valid), 32'd0);
    check("abort.data",  o_mem_rsp_rd_data, 32'd0);
    check("abort.err",   32'(o_mem_rsp_err), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    check("abort.ready", 32'(o_mem_req_ready), 32'd1);
    issue("rd_w_20", 0, 32'h20, 32'h0, MEM_COUNT_WORD, 32'h11223388, 0, 6, 1, a0);

    // Let outstanding responses drain, bounded.
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
